// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the PC fetch sequencer.
//   RESET_PC_DEF / PC_STEP_DEF : default parameter values
//   state_t                    : fetch FSM state encoding
//   align_word()               : clears the byte offset of an address
package pc_seq_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] PC_STEP_DEF  = 32'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      DELIVER = 2'd2
   } state_t;

   function automatic logic [31:0] align_word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pc_reg.sv
// pc_reg: 32-bit program counter register.
//   clk, rst_n : clock, async active-low reset (resets to RESET_PC)
//   ld         : load enable
//   d          : next value
//   q          : current PC
module pc_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld,
   input  logic [31:0] d,
   output logic [31:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= RESET_PC;
      else if (ld) q <= d;
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC and sequences instruction fetch.
//   clk, rst_n                  : clock, async active-low reset
//   imem_req/addr/ack/rdata     : one-at-a-time fetch to instruction memory
//   inst_valid/inst/inst_pc     : fetched word to decode, held until inst_ready
//   inst_ready                  : decode accepts
//   redirect_valid/target       : branch/jump pulse from execute
//   addr_err                    : sticky misaligned-redirect flag, present only
//                                 when PC_FETCH_SEQUENCER_ALIGN_CHECK_EN is defined
// An outstanding memory request is never cancelled: a redirect during a fetch
// is parked in pend_target and applied when the ack arrives.
module pc_fetch_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target
`ifdef PC_FETCH_SEQUENCER_ALIGN_CHECK_EN
  ,output logic        addr_err
`endif
);

   state_t      state, state_n;
   logic [31:0] pc, pc_d;
   logic        pc_ld;
   logic        req_n, vld_n, flush, flush_n;
   logic [31:0] inst_n, ipc_n, pend_target, pend_n, tgt;

   assign tgt       = align_word(redirect_target);
   assign imem_addr = pc;

   pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk  (clk),
      .rst_n(rst_n),
      .ld   (pc_ld),
      .d    (pc_d),
      .q    (pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      pc_ld   = 1'b0;
      pc_d    = pc + PC_STEP;    // wraps modulo 2^32
      req_n   = imem_req;
      vld_n   = inst_valid;
      inst_n  = inst;
      ipc_n   = inst_pc;
      flush_n = flush;
      pend_n  = pend_target;
      case (state)
         IDLE: begin
            state_n = FETCH;
            req_n   = 1'b1;
            if (redirect_valid) begin
               pc_ld = 1'b1;
               pc_d  = tgt;
            end
         end
         FETCH: begin
            if (!imem_req) begin
               // one-cycle gap after a discarded ack; nothing is in flight,
               // so a redirect here can move the PC directly
               req_n = 1'b1;
               if (redirect_valid) begin
                  pc_ld = 1'b1;
                  pc_d  = tgt;
               end
            end else if (imem_ack) begin
               if (redirect_valid || flush) begin
                  // wrong-path data: drop it, restart at the newest target
                  pc_ld   = 1'b1;
                  pc_d    = redirect_valid ? tgt : pend_target;
                  flush_n = 1'b0;
                  req_n   = 1'b0;
               end else begin
                  inst_n  = imem_rdata;
                  ipc_n   = pc;
                  vld_n   = 1'b1;
                  req_n   = 1'b0;
                  state_n = DELIVER;
               end
            end else if (redirect_valid) begin
               flush_n = 1'b1;
               pend_n  = tgt;
            end
         end
         DELIVER: begin
            // redirect takes priority: the held instruction is wrong-path
            if (redirect_valid) begin
               vld_n   = 1'b0;
               pc_ld   = 1'b1;
               pc_d    = tgt;
               req_n   = 1'b1;
               state_n = FETCH;
            end else if (inst_ready) begin
               vld_n   = 1'b0;
               pc_ld   = 1'b1;
               req_n   = 1'b1;
               state_n = FETCH;
            end
         end
         default: begin
            state_n = IDLE;
            req_n   = 1'b0;
            vld_n   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_req    <= 1'b0;
         inst_valid  <= 1'b0;
         inst        <= '0;
         inst_pc     <= '0;
         flush       <= 1'b0;
         pend_target <= '0;
      end else begin
         imem_req    <= req_n;
         inst_valid  <= vld_n;
         inst        <= inst_n;
         inst_pc     <= ipc_n;
         flush       <= flush_n;
         pend_target <= pend_n;
      end
   end

`ifdef PC_FETCH_SEQUENCER_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                           addr_err <= 1'b0;
      else if (redirect_valid && (redirect_target[1:0] != 2'b00)) addr_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed self-checking bench for pc_fetch_sequencer.
// A behavioural instruction memory answers each request after `waits` cycles;
// data for an address is a fixed function of that address.
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_target;
`ifdef PC_FETCH_SEQUENCER_ALIGN_CHECK_EN
   logic        addr_err;
`endif

   int          pass_cnt = 0;
   int          chk_cnt  = 0;
   int          waits    = 0;
   int          wcnt     = 0;
   logic [31:0] ack_q[$];

   always #5 clk = ~clk;

   pc_fetch_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target)
`ifdef PC_FETCH_SEQUENCER_ALIGN_CHECK_EN
     ,.addr_err       (addr_err)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_3000) return 32'h2408_0001;
      return a ^ 32'hA5A5_0000;
   endfunction

   // memory model: ack after `waits` full cycles of imem_req
   always @(negedge clk) begin
      if (!rst_n || !imem_req) begin
         imem_ack = 1'b0;
         wcnt     = 0;
      end else if (wcnt >= waits) begin
         imem_ack   = 1'b1;
         imem_rdata = mem_word(imem_addr);
      end else begin
         imem_ack = 1'b0;
         wcnt++;
      end
   end

   always @(posedge clk)
      if (rst_n && imem_req && imem_ack) ack_q.push_back(imem_addr);

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_valid(input string name, input int max);
      bit ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (inst_valid) begin ok = 1'b1; break; end
      end
      chk_cnt++;
      if (!ok) $display("FAIL %s: inst_valid never rose within %0d cycles", name, max);
      else pass_cnt++;
   endtask

   task automatic redirect(input logic [31:0] t);
      redirect_valid  = 1'b1;
      redirect_target = t;
      tick();
      redirect_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      repeat (3) tick();
      chk_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %h want 0", imem_req); else pass_cnt++;
      chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %h want 0", inst_valid); else pass_cnt++;
      chk_cnt++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h want 0", inst); else pass_cnt++;
      chk_cnt++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc: got %h want 0", inst_pc); else pass_cnt++;
      chk_cnt++; if (imem_addr !== 32'h3000) $display("FAIL rst_addr: got %h want 00003000", imem_addr); else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
      chk_cnt++; if (imem_req !== 1'b0) $display("FAIL idle_req: got %h want 0", imem_req); else pass_cnt++;
   endtask

   task automatic test_zero_wait();
      tick();
      chk_cnt++; if (imem_req !== 1'b1) $display("FAIL zw_req: got %h want 1", imem_req); else pass_cnt++;
      chk_cnt++; if (imem_addr !== 32'h3000) $display("FAIL zw_addr: got %h want 00003000", imem_addr); else pass_cnt++;
      tick();
      chk_cnt++; if (inst_valid !== 1'b1) $display("FAIL zw_valid: got %h want 1", inst_valid); else pass_cnt++;
      chk_cnt++; if (inst !== 32'h2408_0001) $display("FAIL zw_inst: got %h want 24080001", inst); else pass_cnt++;
      chk_cnt++; if (inst_pc !== 32'h3000) $display("FAIL zw_inst_pc: got %h want 00003000", inst_pc); else pass_cnt++;
      chk_cnt++; if (imem_req !== 1'b0) $display("FAIL zw_req_drop: got %h want 0", imem_req); else pass_cnt++;
      tick();
      chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL zw_valid_drop: got %h want 0", inst_valid); else pass_cnt++;
      chk_cnt++; if (imem_addr !== 32'h3004) $display("FAIL zw_next_addr: got %h want 00003004", imem_addr); else pass_cnt++;
      chk_cnt++; if (imem_req !== 1'b1) $display("FAIL zw_next_req: got %h want 1", imem_req); else pass_cnt++;
      inst_ready = 1'b0;
   endtask

   task automatic test_stall();
      tick();
      chk_cnt++; if (inst_pc !== 32'h3004) $display("FAIL st_pc: got %h want 00003004", inst_pc); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_cnt++; if (inst_valid !== 1'b1) $display("FAIL st_valid[%0d]: got %h want 1", i, inst_valid); else pass_cnt++;
         chk_cnt++; if (inst !== 32'hA5A5_3004) $display("FAIL st_inst[%0d]: got %h want a5a53004", i, inst); else pass_cnt++;
         chk_cnt++; if (imem_req !== 1'b0) $display("FAIL st_req[%0d]: got %h want 0", i, imem_req); else pass_cnt++;
         chk_cnt++; if (imem_addr !== 32'h3004) $display("FAIL st_addr[%0d]: got %h want 00003004", i, imem_addr); else pass_cnt++;
      end
      waits = 3; inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk_cnt++; if (imem_addr !== 32'h3008) $display("FAIL st_adv: got %h want 00003008", imem_addr); else pass_cnt++;
      chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL st_valid_drop: got %h want 0", inst_valid); else pass_cnt++;
   endtask

   task automatic test_redirect_fetch();
      ack_q.delete();
      tick();
      redirect(32'h3100);
      chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008)
         $display("FAIL rf_outstanding: got req=%h addr=%h want req=1 addr=00003008", imem_req, imem_addr); else pass_cnt++;
      wait_valid("rf_wait", 30);
      chk_cnt++; if (inst_pc !== 32'h3100) $display("FAIL rf_inst_pc: got %h want 00003100", inst_pc); else pass_cnt++;
      chk_cnt++; if (inst !== 32'hA5A5_3100) $display("FAIL rf_inst: got %h want a5a53100", inst); else pass_cnt++;
      chk_cnt++; if (ack_q.size() != 2 || ack_q[0] !== 32'h3008 || ack_q[1] !== 32'h3100)
         $display("FAIL rf_ack_seq: got %0d acks want 2 (3008,3100)", ack_q.size()); else pass_cnt++;
   endtask

   task automatic test_redirect_deliver();
      waits = 0; inst_ready = 1'b1;
      redirect(32'h3200);
      inst_ready = 1'b0;
      chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL rd_valid: got %h want 0", inst_valid); else pass_cnt++;
      chk_cnt++; if (imem_addr !== 32'h3200) $display("FAIL rd_addr: got %h want 00003200", imem_addr); else pass_cnt++;
      chk_cnt++; if (imem_req !== 1'b1) $display("FAIL rd_req: got %h want 1", imem_req); else pass_cnt++;
      wait_valid("rd_wait", 10);
      chk_cnt++; if (inst_pc !== 32'h3200) $display("FAIL rd_inst_pc: got %h want 00003200", inst_pc); else pass_cnt++;
   endtask

   task automatic test_double_redirect();
      ack_q.delete();
      waits = 3; inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk_cnt++; if (imem_addr !== 32'h3204) $display("FAIL dr_addr: got %h want 00003204", imem_addr); else pass_cnt++;
      tick();
      redirect(32'h3300);
      redirect(32'h3400);
      chk_cnt++; if (imem_addr !== 32'h3204 || imem_req !== 1'b1)
         $display("FAIL dr_held: got req=%h addr=%h want req=1 addr=00003204", imem_req, imem_addr); else pass_cnt++;
      wait_valid("dr_wait", 30);
      chk_cnt++; if (inst_pc !== 32'h3400) $display("FAIL dr_inst_pc: got %h want 00003400", inst_pc); else pass_cnt++;
      chk_cnt++; if (ack_q.size() != 2 || ack_q[0] !== 32'h3204 || ack_q[1] !== 32'h3400)
         $display("FAIL dr_ack_seq: got %0d acks want 2 (3204,3400)", ack_q.size()); else pass_cnt++;
   endtask

   task automatic test_wrap();
      waits = 0;
      redirect(32'hFFFF_FFFC);
      chk_cnt++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wr_addr: got %h want fffffffc", imem_addr); else pass_cnt++;
      wait_valid("wr_wait", 10);
      chk_cnt++; if (inst_pc !== 32'hFFFF_FFFC) $display("FAIL wr_inst_pc: got %h want fffffffc", inst_pc); else pass_cnt++;
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk_cnt++; if (imem_addr !== 32'h0 || imem_req !== 1'b1)
         $display("FAIL wr_wrap: got req=%h addr=%h want req=1 addr=00000000", imem_req, imem_addr); else pass_cnt++;
      wait_valid("wr_wait0", 10);
      chk_cnt++; if (inst_pc !== 32'h0) $display("FAIL wr_inst_pc0: got %h want 00000000", inst_pc); else pass_cnt++;
   endtask

`ifdef PC_FETCH_SEQUENCER_ALIGN_CHECK_EN
   task automatic test_align();
      chk_cnt++; if (addr_err !== 1'b0) $display("FAIL al_pre: got %h want 0", addr_err); else pass_cnt++;
      redirect(32'h3102);
      chk_cnt++; if (addr_err !== 1'b1) $display("FAIL al_set: got %h want 1", addr_err); else pass_cnt++;
      chk_cnt++; if (imem_addr !== 32'h3100) $display("FAIL al_addr: got %h want 00003100", imem_addr); else pass_cnt++;
      wait_valid("al_wait", 10);
      chk_cnt++; if (addr_err !== 1'b1) $display("FAIL al_sticky: got %h want 1", addr_err); else pass_cnt++;
      chk_cnt++; if (inst_pc !== 32'h3100) $display("FAIL al_inst_pc: got %h want 00003100", inst_pc); else pass_cnt++;
   endtask
`endif

   task automatic test_async_reset();
      waits = 3; inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      tick();
      #3 rst_n = 1'b0;
      #1;
      chk_cnt++; if (imem_req !== 1'b0) $display("FAIL ar_req: got %h want 0", imem_req); else pass_cnt++;
      chk_cnt++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0)
         $display("FAIL ar_inst: got valid=%h inst=%h pc=%h want 0/0/0", inst_valid, inst, inst_pc); else pass_cnt++;
      chk_cnt++; if (imem_addr !== 32'h3000) $display("FAIL ar_addr: got %h want 00003000", imem_addr); else pass_cnt++;
`ifdef PC_FETCH_SEQUENCER_ALIGN_CHECK_EN
      chk_cnt++; if (addr_err !== 1'b0) $display("FAIL ar_err: got %h want 0", addr_err); else pass_cnt++;
`endif
      repeat (2) tick();
      waits = 0;
      @(negedge clk); rst_n = 1'b1;
      tick();
      chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000)
         $display("FAIL ar_restart: got req=%h addr=%h want req=1 addr=00003000", imem_req, imem_addr); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_stall();
      test_redirect_fetch();
      test_redirect_deliver();
      test_double_redirect();
      test_wrap();
`ifdef PC_FETCH_SEQUENCER_ALIGN_CHECK_EN
      test_align();
`endif
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Owns the program counter and sequences instruction fetch for the multi-cycle MIPS core. It issues one request at a time to instruction memory over a req/ack handshake and delivers each fetched word with its PC over a valid/ready handshake to decode. It also absorbs redirect pulses (branch, j, jal, jr) from execute and flushes the wrong-path fetch without ever cancelling an outstanding memory request.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
PC_STEP, 4, sequential increment in bytes.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
imem_req  output  1  fetch request; registered.
imem_addr  output  32  fetch address; equals pc; stable while imem_req=1.
imem_ack  input  1  memory has returned data this cycle; ignored when imem_req=0.
imem_rdata  input  32  instruction word, valid when imem_ack=1.
inst_valid  output  1  instruction available to decode.
inst  output  32  instruction word.
inst_pc  output  32  address of inst.
inst_ready  input  1  decode accepts inst this cycle.
redirect_valid  input  1  single-cycle redirect pulse from execute.
redirect_target  input  32  new PC; bits [1:0] are forced to 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, imem_req=0, inst_valid=0, inst=0, inst_pc=0, flush=0, pend_target=0. Reset mid-fetch abandons the fetch; a late imem_ack is ignored because imem_req=0.
- IDLE: lasts one cycle after reset release, then goes to FETCH with imem_req=1. With a redirect, pc<=target first.
- FETCH: imem_req=1 and imem_addr=pc, held until imem_ack.
  - On ack with flush=0: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, imem_req<=0, go to DELIVER.
  - On ack with flush=1: discard the data, pc<=pend_target, flush<=0, stay in FETCH. imem_req drops for one cycle, then reasserts at the new address.
- DELIVER: inst_valid=1; inst and inst_pc are held stable until inst_ready.
  - On inst_ready: inst_valid<=0, pc<=pc+PC_STEP, go to FETCH (imem_req<=1).
- Redirect rules:
  - In DELIVER, redirect wins over inst_ready. The held instruction is dropped, inst_valid<=0, pc<=target, go to FETCH.
  - In FETCH without ack: flush<=1, pend_target<=target. If another redirect arrives before ack, the latest target wins.
  - In FETCH coincident with ack: data is discarded and the redirect target is used directly, as in the ack-with-flush case.
- Latency: with zero-wait memory (ack in the same cycle as req), inst_valid rises the cycle after ack. Peak throughput is 1 instruction per 2 cycles.
- Arithmetic: pc+PC_STEP is modulo 2^32, so 32'hFFFF_FFFC goes to 32'h0000_0000.

Optional Feature:
Macro PC_FETCH_SEQUENCER_ALIGN_CHECK_EN.
- Defined: adds output addr_err (1 bit, reset 0). It is set the cycle after a redirect_valid whose redirect_target[1:0]!=0, and stays set until reset. The PC still takes the target with bits [1:0] cleared.
- Undefined: the port is absent and misalignment is cleared silently.

Decomposition:
- Package pc_seq_pkg holds: RESET_PC and PC_STEP defaults; the state encoding IDLE=2'd0, FETCH=2'd1, DELIVER=2'd2.
- Sub-module pc_reg: a 32-bit register with async active-low reset to RESET_PC, a load enable and a data input. The FSM and the next-pc mux stay in the top module.

Test Plan:
- Reset release, zero-wait memory returning 32'h2408_0001 at 0x3000, inst_ready=1 -> imem_req at cycle 2 with addr 0x3000; inst_valid with inst_pc=0x3000; next request at 0x3004.
- inst_ready=0 for 5 cycles in DELIVER -> inst and inst_pc unchanged; no imem_req; pc advances only on ready.
- Redirect to 0x3100 while a 3-wait-state fetch to 0x3008 is outstanding -> the ack data is discarded; no inst_valid for 0x3008; the next request is at 0x3100.
- Redirect to 0x3200 in the same cycle as inst_ready in DELIVER -> the instruction is not counted as delivered; next fetch at 0x3200.
- Two redirects (0x3300 then 0x3400) before ack -> fetch resumes at 0x3400; pc at 0xFFFF_FFFC accepted -> next fetch at 0x0000_0000.
- With the macro defined, redirect to 0x3102 -> fetch at 0x3100 and addr_err=1 sticky; rst_n low mid-fetch -> all outputs return to their reset values immediately.
